// File: rtl/rs232_tx.sv
// rs232_tx: UART transmitter. One-entry holding register on a valid/ready
// handshake feeds a shifter that sends start, 8 data, optional parity and
// 1 or 2 stop bits. A byte queued mid-frame goes out with no idle gap.
module rs232_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int N_BIT_STOP   = 1,
  parameter int PARITY_BIT   = 0,
  parameter int PARITY_ODD   = 0,
  parameter int MSB_FIRST    = 0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       txd_out,
  output logic       busy_out
);

  localparam int BAUD_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

  // Reject parameter sets the frame sequencer cannot honour.
  if (N_BIT_STOP < 1 || N_BIT_STOP > 2) begin : g_bad_stop
    $error("rs232_tx: N_BIT_STOP must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("rs232_tx: CLKS_PER_BIT must be >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [2:0]          r_bitcnt;
  logic [7:0]          r_hold;
  logic                r_hold_full;
  logic [7:0]          r_shift;
  logic                r_par;
  logic                r_txd;

  logic                w_baud_last;
  logic                w_stop_done;
  logic                w_load;
  logic                w_bit;

  assign w_baud_last = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_stop_done = w_baud_last && (r_bitcnt == 3'(N_BIT_STOP - 1));
  // The shifter reloads from an idle line, or straight out of the last stop cycle.
  assign w_load      = r_hold_full &&
                       ((r_state == IDLE) || ((r_state == STOP) && w_stop_done));
  assign w_bit       = (MSB_FIRST != 0) ? r_shift[7] : r_shift[0];

  assign ready_out = !r_hold_full;
  assign txd_out   = r_txd;
  assign busy_out  = (r_state != IDLE) || r_hold_full;

  // Handshake capture plus frame sequencer; txd is registered at each bit boundary.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_baud      <= '0;
      r_bitcnt    <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_txd       <= 1'b1;
    end else begin
      // A draining edge never accepts: ready was low on that edge.
      if (w_load) begin
        r_hold_full <= 1'b0;
        r_shift     <= r_hold;
        r_par       <= (^r_hold) ^ 1'(PARITY_ODD);
      end else if (valid_in && !r_hold_full) begin
        r_hold      <= data_in;
        r_hold_full <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_baud   <= '0;
          r_bitcnt <= '0;
          r_txd    <= 1'b1;
          if (r_hold_full) begin
            r_state <= START;
            r_txd   <= 1'b0;
          end
        end
        START: begin
          if (w_baud_last) begin
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_state  <= DATA;
            r_txd    <= w_bit;
            r_shift  <= (MSB_FIRST != 0) ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bitcnt == 3'd7) begin
              r_bitcnt <= '0;
              if (PARITY_BIT != 0) begin
                r_state <= PARITY;
                r_txd   <= r_par;
              end else begin
                r_state <= STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
              r_txd    <= w_bit;
              r_shift  <= (MSB_FIRST != 0) ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        PARITY: begin
          if (w_baud_last) begin
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_state  <= STOP;
            r_txd    <= 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (w_stop_done) begin
              r_bitcnt <= '0;
              if (r_hold_full) begin
                r_state <= START;
                r_txd   <= 1'b0;
              end else begin
                r_state <= IDLE;
                r_txd   <= 1'b1;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_tx.sv
// tb_rs232_tx: directed bench for rs232_tx. Four instances cover the default
// frame, even/odd parity and two-stop-bit MSB-first framing at 4 clocks/bit.
module tb_rs232_tx;

  localparam int CPB = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [3:0] valid_in = 4'b0000;
  logic [3:0] ready_out;
  logic [3:0] txd_out;
  logic [3:0] busy_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  rs232_tx #(.CLKS_PER_BIT(CPB)) u0 (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in[0]),
    .ready_out(ready_out[0]), .txd_out(txd_out[0]), .busy_out(busy_out[0]));

  rs232_tx #(.CLKS_PER_BIT(CPB), .PARITY_BIT(1), .PARITY_ODD(0)) u1 (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in[1]),
    .ready_out(ready_out[1]), .txd_out(txd_out[1]), .busy_out(busy_out[1]));

  rs232_tx #(.CLKS_PER_BIT(CPB), .PARITY_BIT(1), .PARITY_ODD(1)) u2 (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in[2]),
    .ready_out(ready_out[2]), .txd_out(txd_out[2]), .busy_out(busy_out[2]));

  rs232_tx #(.CLKS_PER_BIT(CPB), .N_BIT_STOP(2), .MSB_FIRST(1)) u3 (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in[3]),
    .ready_out(ready_out[3]), .txd_out(txd_out[3]), .busy_out(busy_out[3]));

  // Frame bits in send order: first-sent bit sits at [nbits-1].
  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [11:0] frame;
    int         nbits;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Send one byte to one instance and check every cycle of its frame.
  task automatic send_and_check(input int inst, input logic [7:0] d,
                                input logic [11:0] frame, input int nbits);
    @(negedge clk_in);
    data_in = d;
    valid_in[inst] = 1'b1;
    @(posedge clk_in);
    #1 valid_in[inst] = 1'b0;
    @(negedge clk_in);
    chk("pre_start_txd", txd_out[inst], 1'b1);
    chk("accept_ready", ready_out[inst], 1'b0);
    chk("accept_busy", busy_out[inst], 1'b1);
    for (int c = 0; c < nbits * CPB; c++) begin
      @(negedge clk_in);
      chk($sformatf("frame_i%0d_d%02h_c%0d", inst, d, c), txd_out[inst], frame[nbits - 1 - c / CPB]);
      chk("frame_busy", busy_out[inst], 1'b1);
    end
    @(negedge clk_in);
    chk("end_busy", busy_out[inst], 1'b0);
    chk("end_txd", txd_out[inst], 1'b1);
    chk("end_ready", ready_out[inst], 1'b1);
  endtask

  logic [19:0] b2b;
  logic        exp_rdy;

  initial begin
    vecs[0] = '{inst: 0, data: 8'h55, frame: 12'(10'b0101010101),  nbits: 10};
    vecs[1] = '{inst: 0, data: 8'hA5, frame: 12'(10'b0101001011),  nbits: 10};
    vecs[2] = '{inst: 1, data: 8'h07, frame: 12'(11'b01110000011), nbits: 11};
    vecs[3] = '{inst: 2, data: 8'h07, frame: 12'(11'b01110000001), nbits: 11};
    vecs[4] = '{inst: 3, data: 8'h80, frame: 12'(11'b01000000011), nbits: 11};
    vecs[5] = '{inst: 1, data: 8'h00, frame: 12'(11'b00000000001), nbits: 11};
    vecs[6] = '{inst: 3, data: 8'h01, frame: 12'(11'b00000000111), nbits: 11};
    vecs[7] = '{inst: 0, data: 8'h0F, frame: 12'(10'b0111100001),  nbits: 10};

    // Reset state, then an idle line with valid low.
    #12;
    for (int i = 0; i < 4; i++) begin
      chk("rst_txd", txd_out[i], 1'b1);
      chk("rst_ready", ready_out[i], 1'b1);
      chk("rst_busy", busy_out[i], 1'b0);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      chk("idle_txd", txd_out[0], 1'b1);
      chk("idle_busy", busy_out[0], 1'b0);
    end

    // Table-driven single frames.
    for (int v = 0; v < 8; v++)
      send_and_check(vecs[v].inst, vecs[v].data, vecs[v].frame, vecs[v].nbits);

    // Back-to-back: 0xA5 then 0x3C queued during 0xA5's data bits.
    b2b = {10'b0101001011, 10'b0001111001};
    @(negedge clk_in);
    data_in = 8'hA5;
    valid_in[0] = 1'b1;
    @(posedge clk_in);
    #1 valid_in[0] = 1'b0;
    @(negedge clk_in);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_in);
      exp_rdy = (c <= 12 || c >= 40);
      chk($sformatf("b2b_txd_c%0d", c), txd_out[0], b2b[19 - c / CPB]);
      chk($sformatf("b2b_ready_c%0d", c), ready_out[0], exp_rdy);
      chk("b2b_busy", busy_out[0], 1'b1);
      if (c == 12) begin
        data_in = 8'h3C;
        valid_in[0] = 1'b1;
      end
      if (c == 13) valid_in[0] = 1'b0;
    end
    @(negedge clk_in);
    chk("b2b_end_busy", busy_out[0], 1'b0);

    // Reset mid-frame during data bit 3 with a byte pending.
    @(negedge clk_in);
    data_in = 8'h55;
    valid_in[0] = 1'b1;
    @(posedge clk_in);
    #1 valid_in[0] = 1'b0;
    @(negedge clk_in);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk_in);
      if (c == 6) begin
        data_in = 8'hC3;
        valid_in[0] = 1'b1;
      end
      if (c == 7) valid_in[0] = 1'b0;
    end
    chk("mid_pending_ready", ready_out[0], 1'b0);
    chk("mid_bit3_txd", txd_out[0], 1'b0);
    #1 rst_in = 1'b1;
    #1;
    chk("mid_rst_txd", txd_out[0], 1'b1);
    chk("mid_rst_ready", ready_out[0], 1'b1);
    chk("mid_rst_busy", busy_out[0], 1'b0);
    #1 rst_in = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_in);
      chk("post_rst_txd", txd_out[0], 1'b1);
      chk("post_rst_busy", busy_out[0], 1'b0);
    end
    send_and_check(0, 8'h0F, 12'(10'b0111100001), 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
